// File: rtl/csr_file.sv
// Machine-mode CSR storage with read-modify-write, 64-bit mcycle/minstret counters
// and illegal-access detection for the trap logic.
module csr_file #(
  parameter logic [31:0] HART_ID = 32'd0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        valid_i,
  input  logic [1:0]  csr_control_i,
  input  logic        csr_src_i,
  input  logic [11:0] csr_addr_i,
  input  logic [4:0]  rs1_idx_i,
  input  logic [31:0] rs1_data_i,
  input  logic        instr_retired_i,
  output logic [31:0] csr_rdata_o,
  output logic        illegal_o
);

  localparam logic [1:0] CSR_PASS  = 2'b00;
  localparam logic [1:0] CSR_SET   = 2'b01;
  localparam logic [1:0] CSR_CLEAR = 2'b10;
  localparam logic [1:0] CSR_NA    = 2'b11;
  localparam logic       CSR_SRC_IMM = 1'b1;

  logic [31:0] mscratch;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] src;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        active;
  logic        implemented;
  logic        wr_intent;
  logic        illegal;
  logic        do_write;

  // valid_i alone qualifies an access: there is no ready, the unit accepts one
  // access every cycle valid_i is high and never stalls the pipeline.
  always_comb begin
    src         = (csr_src_i == CSR_SRC_IMM) ? {27'b0, rs1_idx_i} : rs1_data_i;
    active      = reset_n_i && valid_i && (csr_control_i != CSR_NA);
    wr_intent   = (csr_control_i == CSR_PASS) || (rs1_idx_i != 5'd0);
    implemented = 1'b1;
    old_val     = 32'd0;
    case (csr_addr_i)
      12'h340:          old_val = mscratch;
      12'hB00, 12'hC00: old_val = mcycle[31:0];
      12'hB80, 12'hC80: old_val = mcycle[63:32];
      12'hB02, 12'hC02: old_val = minstret[31:0];
      12'hB82, 12'hC82: old_val = minstret[63:32];
      12'hF14:          old_val = HART_ID;
      default:          implemented = 1'b0;
    endcase
    illegal  = active && (!implemented || (wr_intent && (csr_addr_i[11:10] == 2'b11)));
    do_write = active && !illegal && wr_intent;
    case (csr_control_i)
      CSR_PASS:  new_val = src;
      CSR_SET:   new_val = old_val | src;
      CSR_CLEAR: new_val = old_val & ~src;
      default:   new_val = old_val;
    endcase
  end

  assign csr_rdata_o = (active && !illegal) ? old_val : 32'd0;
  assign illegal_o   = illegal;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mscratch <= 32'd0;
    end else if (do_write && (csr_addr_i == 12'h340)) begin
      mscratch <= new_val;
    end
  end

  // A write to either half replaces that cycle's increment entirely.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mcycle <= 64'd0;
    end else if (do_write && (csr_addr_i == 12'hB00)) begin
      mcycle[31:0] <= new_val;
    end else if (do_write && (csr_addr_i == 12'hB80)) begin
      mcycle[63:32] <= new_val;
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      minstret <= 64'd0;
    end else if (do_write && (csr_addr_i == 12'hB02)) begin
      minstret[31:0] <= new_val;
    end else if (do_write && (csr_addr_i == 12'hB82)) begin
      minstret[63:32] <= new_val;
    end else if (instr_retired_i) begin
      minstret <= minstret + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus random accesses
// compared against a behavioural CSR model.
module tb_csr_file;

  localparam logic [31:0] HART = 32'h0000_0007;
  localparam logic [1:0] PASS = 2'b00, SET = 2'b01, CLR = 2'b10, NA = 2'b11;
  localparam bit REG = 1'b0, IMM = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  ctrl = NA;
  logic        src_sel = REG;
  logic [11:0] addr = 12'h0;
  logic [4:0]  idx = 5'd0;
  logic [31:0] data = 32'd0;
  logic        retired = 1'b0;
  logic [31:0] rdata;
  logic        illegal;

  csr_file #(.HART_ID(HART)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid), .csr_control_i(ctrl),
    .csr_src_i(src_sel), .csr_addr_i(addr), .rs1_idx_i(idx), .rs1_data_i(data),
    .instr_retired_i(retired), .csr_rdata_o(rdata), .illegal_o(illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  logic        last_ill;

  // behavioural model state
  logic [31:0]     m_scratch;
  longint unsigned m_cycle;
  longint unsigned m_instret;

  function automatic void model_read(input logic [11:0] a, output bit impl,
                                     output logic [31:0] v);
    impl = 1'b1;
    v = 32'd0;
    if (a == 12'h340) v = m_scratch;
    else if (a == 12'hB00 || a == 12'hC00) v = m_cycle[31:0];
    else if (a == 12'hB80 || a == 12'hC80) v = m_cycle[63:32];
    else if (a == 12'hB02 || a == 12'hC02) v = m_instret[31:0];
    else if (a == 12'hB82 || a == 12'hC82) v = m_instret[63:32];
    else if (a == 12'hF14) v = HART;
    else impl = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_scratch = 32'd0;
    m_cycle   = 64'd0;
    m_instret = 64'd0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input bit v, input logic [1:0] c, input bit s, input logic [11:0] a,
                      input logic [4:0] ix, input logic [31:0] d, input bit ret);
    bit impl, active, intent, exp_ill, wr;
    logic [31:0] old, op, nv;
    longint unsigned cyc_n, ins_n;
    valid = v; ctrl = c; src_sel = s; addr = a; idx = ix; data = d; retired = ret;
    model_read(a, impl, old);
    active  = v && (c != NA);
    intent  = (c == PASS) || (ix != 5'd0);
    exp_ill = active && (!impl || (intent && (a[11:10] == 2'b11)));
    wr      = active && !exp_ill && intent;
    exp_q.push_back((active && !exp_ill) ? old : 32'd0);
    @(negedge clk);
    last_rd  = rdata;
    last_ill = illegal;
    chk($sformatf("rdata@%h", a), last_rd, exp_q.pop_front());
    chk($sformatf("illegal@%h", a), {31'd0, last_ill}, {31'd0, exp_ill});
    op = s ? {27'd0, ix} : d;
    nv = (c == PASS) ? op : (c == SET) ? (old | op) : (old & ~op);
    cyc_n = m_cycle + 1;
    ins_n = m_instret + (ret ? 1 : 0);
    if (wr) begin
      if (a == 12'h340) m_scratch = nv;
      if (a == 12'hB00) cyc_n = {m_cycle[63:32], nv};
      if (a == 12'hB80) cyc_n = {nv, m_cycle[31:0]};
      if (a == 12'hB02) ins_n = {m_instret[63:32], nv};
      if (a == 12'hB82) ins_n = {nv, m_instret[31:0]};
    end
    @(posedge clk);
    m_cycle = cyc_n;
    m_instret = ins_n;
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input bit ret);
    step(1'b1, SET, IMM, a, 5'd0, 32'd0, ret);
  endtask

  logic [11:0] addr_tbl [14] = '{12'h340, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                                 12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h341,
                                 12'h340, 12'hB02};

  initial begin
    model_reset();
    valid = 1'b1; ctrl = SET; addr = 12'hF14;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // first cycle after release reads mcycle = 0
    rd(12'hB00, 0);                chk("mcycle_first", last_rd, 32'd0);
    step(1, PASS, REG, 12'h340, 5'd1, 32'hDEAD_BEEF, 0);
    chk("pass_old", last_rd, 32'd0);
    rd(12'h340, 0);                chk("pass_new", last_rd, 32'hDEAD_BEEF);
    step(1, PASS, REG, 12'h340, 5'd1, 32'h0000_0F00, 0);
    step(1, SET, IMM, 12'h340, 5'h0A, 32'hFFFF_FFFF, 0);
    chk("set_old", last_rd, 32'h0000_0F00);
    step(1, CLR, REG, 12'h340, 5'd3, 32'h0000_0F00, 0);
    chk("clr_old", last_rd, 32'h0000_0F0A);
    rd(12'h340, 0);                chk("clr_new", last_rd, 32'h0000_000A);

    // mcycle wrap
    step(1, PASS, REG, 12'hB80, 5'd1, 32'hFFFF_FFFF, 0);
    chk("mcycleh_old", last_rd, 32'd0);
    step(1, PASS, REG, 12'hB00, 5'd1, 32'hFFFF_FFFE, 0);
    rd(12'hB80, 0);                chk("mcycleh_set", last_rd, 32'hFFFF_FFFF);
    rd(12'hB00, 0);                chk("mcycle_ff", last_rd, 32'hFFFF_FFFF);
    rd(12'hB00, 0);                chk("mcycle_wrap_lo", last_rd, 32'd0);
    rd(12'hB80, 0);                chk("mcycle_wrap_hi", last_rd, 32'd0);

    // minstret write beats retire
    repeat (3) step(0, PASS, REG, 12'h340, 5'd1, 32'h0, 1);
    rd(12'hB02, 0);                chk("minstret_3", last_rd, 32'd3);
    step(1, PASS, REG, 12'hB02, 5'd1, 32'h10, 1);
    rd(12'hB02, 1);                chk("minstret_wr", last_rd, 32'h10);
    rd(12'hB02, 0);                chk("minstret_inc", last_rd, 32'h11);

    // illegal accesses
    step(1, PASS, REG, 12'hC00, 5'd1, 32'h5, 0);
    chk("ro_write_ill", {31'd0, last_ill}, 32'd1);
    step(1, SET, REG, 12'hC00, 5'd0, 32'hFFFF, 0);
    chk("ro_read_ok", {31'd0, last_ill}, 32'd0);
    step(1, CLR, REG, 12'h7C0, 5'd0, 32'h0, 0);
    chk("unimpl_ill", {31'd0, last_ill}, 32'd1);
    chk("unimpl_rd", last_rd, 32'd0);
    rd(12'hF14, 0);                chk("hartid", last_rd, HART);
    step(1, PASS, IMM, 12'hF14, 5'd4, 32'h0, 0);
    chk("hartid_wr_ill", {31'd0, last_ill}, 32'd1);

    // inactive accesses
    step(0, PASS, REG, 12'h340, 5'd1, 32'h55, 0);
    step(1, NA, REG, 12'h7C0, 5'd1, 32'h66, 0);
    chk("na_ill", {31'd0, last_ill}, 32'd0);
    rd(12'h340, 0);                chk("no_write", last_rd, 32'h0000_000A);

    // randomized accesses against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r_idx;
      r_idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step(bit'($urandom_range(0, 7) != 0), 2'($urandom), bit'($urandom),
           addr_tbl[$urandom_range(0, 13)], r_idx,
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
           bit'($urandom));
    end

    // reset asserted in the middle of a write cycle
    valid = 1; ctrl = PASS; src_sel = REG; addr = 12'h340; idx = 5'd1; data = 32'h1234_5678;
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_rdata", rdata, 32'd0);
    chk("midreset_illegal", {31'd0, illegal}, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    rd(12'hB00, 0);                chk("post_mcycle", last_rd, 32'd0);
    rd(12'h340, 0);                chk("post_scratch", last_rd, 32'd0);
    rd(12'hB80, 0);
    rd(12'hB02, 0);                chk("post_minstret", last_rd, 32'd0);
    rd(12'hB82, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
